// File: rtl/p2s_block_tx_if.sv
// Handshake bundle for p2s_block_tx: parallel block in, serial word stream out.
// master = block producer / word consumer; slave = the transmitter.
interface p2s_block_tx_if #(
  parameter int BLOCK_SIZE = 4,
  parameter int WORD_SIZE  = 8
);
  logic [BLOCK_SIZE*WORD_SIZE-1:0] p_data;
  logic                            p_valid;
  logic                            p_ready;
  logic [WORD_SIZE-1:0]            s_data;
  logic                            s_valid;
  logic                            s_ready;
  logic                            s_first;
  logic                            s_last;
  logic                            busy;

  modport master (
    output p_data, p_valid, s_ready,
    input  p_ready, s_data, s_valid, s_first, s_last, busy
  );

  modport slave (
    input  p_data, p_valid, s_ready,
    output p_ready, s_data, s_valid, s_first, s_last, busy
  );
endinterface

// File: rtl/p2s_block_tx.sv
// Parallel-to-serial block transmitter: word 0 first, with one pending-block
// buffer so back-to-back blocks stream without a bubble.
module p2s_block_tx #(
  parameter int BLOCK_SIZE = 4,
  parameter int WORD_SIZE  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  p2s_block_tx_if.slave   bus
);
  localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                                r_state;
  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0]  r_shreg;
  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0]  r_pend;
  logic                                  r_pend_full;
  logic [CW-1:0]                         r_cnt;

  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0]  w_shift;
  logic                                  w_active;
  logic                                  w_accept;
  logic                                  w_xfer;
  logic                                  w_lastw;

  // Right shift by one word, zero fill at the top so the register drains to 0.
  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_shift
    if (k == BLOCK_SIZE-1) begin : g_top
      assign w_shift[k] = '0;
    end else begin : g_mid
      assign w_shift[k] = r_shreg[k+1];
    end
  end

  assign w_active = (r_state == SHIFT);
  assign w_lastw  = (r_cnt == CW'(BLOCK_SIZE-1));
  assign w_accept = bus.p_valid && bus.p_ready;
  assign w_xfer   = w_active && bus.s_ready;

  assign bus.p_ready = rst_n && !r_pend_full;
  assign bus.s_data  = r_shreg[0];
  assign bus.s_valid = w_active;
  assign bus.s_first = w_active && (r_cnt == '0);
  assign bus.s_last  = w_active && w_lastw;
  assign bus.busy    = w_active || r_pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= bus.p_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_xfer && w_lastw) begin
            r_cnt <= '0;
            // Pending block has priority; accept is blocked while it is full.
            if (r_pend_full) begin
              r_shreg     <= r_pend;
              r_pend_full <= 1'b0;
            end else if (w_accept) begin
              r_shreg <= bus.p_data;
            end else begin
              r_shreg <= w_shift;
              r_state <= IDLE;
            end
          end else begin
            if (w_xfer) begin
              r_shreg <= w_shift;
              r_cnt   <= r_cnt + CW'(1);
            end
            if (w_accept) begin
              r_pend      <= bus.p_data;
              r_pend_full <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_p2s_block_tx.sv
// Bench for p2s_block_tx: table of block/backpressure scenarios checked by a
// word scoreboard, plus hand sequences for reset, latency and reassembly.
module tb_p2s_block_tx;
  localparam int BS = 4;
  localparam int WS = 8;
  localparam int BW = BS*WS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p2s_block_tx_if #(.BLOCK_SIZE(BS), .WORD_SIZE(WS)) bus ();
  p2s_block_tx #(.BLOCK_SIZE(BS), .WORD_SIZE(WS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [WS-1:0] d;
    logic          f;
    logic          l;
  } exp_t;

  typedef struct {
    logic [BW-1:0] blk [3];
    int            nblk;
    logic [7:0]    pat;      // s_ready per valid cycle, bit k%plen
    int            plen;
    int            exp_vcyc; // cycles with s_valid=1
    int            exp_lo;   // cycles with p_ready=0
  } vec_t;

  exp_t sbq[$];
  vec_t tv[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_block(input logic [BW-1:0] b);
    exp_t e;
    for (int k = 0; k < BS; k++) begin
      e.d = b[k*WS +: WS];
      e.f = (k == 0);
      e.l = (k == BS-1);
      sbq.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int acc = 0, vc = 0, lo = 0, xfers = 0, cyc = 0;
    logic [WS-1:0] prev_d = '0;
    logic prev_stall = 1'b0;
    exp_t e;
    sbq.delete();
    while (cyc < 300) begin
      @(negedge clk);
      if (acc == v.nblk && !bus.s_valid) break;
      bus.p_valid = (acc < v.nblk);
      bus.p_data  = (acc < v.nblk) ? v.blk[acc] : '0;
      bus.s_ready = bus.s_valid ? v.pat[vc % v.plen] : 1'b0;
      #1;
      if (!bus.p_ready) lo++;
      if (prev_stall) begin
        chk($sformatf("v%0d_hold_valid", id), 64'(bus.s_valid), 64'(1));
        chk($sformatf("v%0d_hold_data", id), 64'(bus.s_data), 64'(prev_d));
      end
      if (bus.s_valid) begin
        vc++;
        if (bus.s_ready) begin
          xfers++;
          if (sbq.size() == 0) begin
            chk($sformatf("v%0d_sb_underflow", id), 64'(1), 64'(0));
          end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d_data", id), 64'(bus.s_data), 64'(e.d));
            chk($sformatf("v%0d_first_last", id), {62'(0), bus.s_first, bus.s_last}, {62'(0), e.f, e.l});
          end
        end
      end
      prev_stall = bus.s_valid && !bus.s_ready;
      prev_d     = bus.s_data;
      if (bus.p_valid && bus.p_ready) begin
        push_block(bus.p_data);
        acc++;
      end
      cyc++;
    end
    chk($sformatf("v%0d_timeout", id), 64'(cyc < 300), 64'(1));
    chk($sformatf("v%0d_xfers", id), 64'(xfers), 64'(v.nblk*BS));
    chk($sformatf("v%0d_valid_cycles", id), 64'(vc), 64'(v.exp_vcyc));
    chk($sformatf("v%0d_pready_low", id), 64'(lo), 64'(v.exp_lo));
    chk($sformatf("v%0d_sb_left", id), 64'(sbq.size()), 64'(0));
    chk($sformatf("v%0d_idle_data", id), 64'(bus.s_data), 64'(0));
    chk($sformatf("v%0d_idle_flags", id), {60'(0), bus.s_first, bus.s_last, bus.busy, bus.p_ready},
        {60'(0), 1'b0, 1'b0, 1'b0, 1'b1});
    bus.p_valid = 1'b0;
    bus.s_ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm, input logic exp_pr);
    chk({nm, "_sdata"}, 64'(bus.s_data), 64'(0));
    chk({nm, "_flags"}, {59'(0), bus.s_valid, bus.s_first, bus.s_last, bus.busy, bus.p_ready},
        {59'(0), 4'b0000, exp_pr});
  endtask

  initial begin
    logic [BW-1:0] asm_blk;
    int widx, guard;

    bus.p_data  = '0;
    bus.p_valid = 1'b0;
    bus.s_ready = 1'b0;

    tv[0] = '{blk: '{32'h44332211, 32'h0, 32'h0}, nblk: 1, pat: 8'h01, plen: 1, exp_vcyc: 4,  exp_lo: 0};
    tv[1] = '{blk: '{32'h44332211, 32'h88776655, 32'h0}, nblk: 2, pat: 8'h01, plen: 1, exp_vcyc: 8, exp_lo: 3};
    tv[2] = '{blk: '{32'h44332211, 32'h0, 32'h0}, nblk: 1, pat: 8'h59, plen: 7, exp_vcyc: 7,  exp_lo: 0};
    tv[3] = '{blk: '{32'hA1B2C3D4, 32'h0F1E2D3C, 32'hFFEE0001}, nblk: 3, pat: 8'h01, plen: 1, exp_vcyc: 12, exp_lo: 6};
    tv[4] = '{blk: '{32'h12345678, 32'h9ABCDEF0, 32'h0}, nblk: 2, pat: 8'h01, plen: 2, exp_vcyc: 15, exp_lo: 6};
    tv[5] = '{blk: '{32'h01020304, 32'h05060708, 32'h090A0B0C}, nblk: 3, pat: 8'h02, plen: 2, exp_vcyc: 24, exp_lo: 14};
    tv[6] = '{blk: '{32'h11111111, 32'h22222222, 32'h33333333}, nblk: 3, pat: 8'hF0, plen: 8, exp_vcyc: 24, exp_lo: 14};

    // Power-on reset: everything low, including p_ready.
    #1;
    chk_reset_outs("por", 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_outs("por_release", 1'b1);

    for (int i = 0; i < 7; i++) run_vec(tv[i], i);

    // Latency and reassembly: word 0 one cycle after accept, s2p-style rebuild.
    @(negedge clk);
    bus.p_data  = 32'hDEADBEEF;
    bus.p_valid = 1'b1;
    bus.s_ready = 1'b1;
    @(negedge clk);
    bus.p_valid = 1'b0;
    bus.p_data  = '0;
    #1;
    chk("lat_first", {61'(0), bus.s_valid, bus.s_first, bus.s_last}, {61'(0), 3'b110});
    chk("lat_word0", 64'(bus.s_data), 64'hEF);
    asm_blk = '0;
    widx = 0;
    guard = 0;
    while (bus.s_valid && guard < 10) begin
      if (bus.s_first) widx = 0;
      asm_blk[widx*WS +: WS] = bus.s_data;
      widx++;
      @(negedge clk);
      #1;
      guard++;
    end
    chk("loop_words", 64'(widx), 64'(BS));
    chk("loop_block", 64'(asm_blk), 64'hDEADBEEF);
    chk("loop_idle", {62'(0), bus.s_valid, bus.busy}, 64'(0));

    // Reset mid-block with a pending block: outputs drop at once, nothing resumes.
    bus.s_ready = 1'b0;
    bus.p_valid = 1'b1;
    bus.p_data  = 32'hCAFEF00D;
    @(negedge clk);
    bus.p_data  = 32'h0BADBEEF;
    @(negedge clk);
    bus.p_valid = 1'b0;
    #1;
    chk("pre_rst_pend", {62'(0), bus.p_ready, bus.busy}, {62'(0), 2'b01});
    chk("pre_rst_word", 64'(bus.s_data), 64'h0D);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.s_ready = 1'b1;
    #1;
    chk_reset_outs("rst_release", 1'b1);
    @(negedge clk);
    #1;
    chk_reset_outs("rst_no_resume", 1'b1);

    // Stream still works after an abort.
    run_vec(tv[1], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/p2s_block_tx.md
# p2s_block_tx

Parallel-to-serial block transmitter, the transmit-side counterpart of `s2p`. Accepts a full block of BLOCK_SIZE words in parallel via a valid/ready handshake and emits it one word per transfer on a serial valid/ready word stream, word 0 (least-significant word) first. This ordering lets `s2p` reassemble the original block without reordering. One pending-block buffer allows a new block to be accepted while the current one is shifting, so back-to-back blocks stream with no bubble.

## Interface
Parameters:
- BLOCK_SIZE, 4, words per block (≥2)
- WORD_SIZE, 8, bits per word

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- p_data  in  BLOCK_SIZE*WORD_SIZE  parallel block; word k = p_data[k*WORD_SIZE +: WORD_SIZE]
- p_valid  in  1  p_data valid
- p_ready  out  1  block accepted when p_valid && p_ready
- s_data  out  WORD_SIZE  current serial word
- s_valid  out  1  s_data valid
- s_ready  in  1  word transferred when s_valid && s_ready
- s_first  out  1  s_valid && current word is word 0
- s_last  out  1  s_valid && current word is word BLOCK_SIZE-1
- busy  out  1  active || pend_full

## Operation
- State: shift register `shreg` (BLOCK_SIZE*WORD_SIZE), word counter `cnt` (0..BLOCK_SIZE-1), `active` flag, pending buffer `pend` with `pend_full` flag.
- States: IDLE (active=0), SHIFT (active=1).
- Outputs: s_data = shreg[WORD_SIZE-1:0]; s_valid = active; p_ready = rst_n && !pend_full.
- IDLE, accept: shreg←p_data, cnt←0, go to SHIFT.
- SHIFT, transfer with cnt<BLOCK_SIZE-1: shreg shifts right by WORD_SIZE with zero fill; cnt++.
- SHIFT, transfer with cnt=BLOCK_SIZE-1 (last word):
  - If pend_full: shreg←pend, pend_full←0, cnt←0, stay in SHIFT.
  - Else, if an accept occurs in the same cycle: shreg←p_data, cnt←0, stay in SHIFT.
  - Else: shreg shifts (becomes all zero), cnt←0, go to IDLE.
- SHIFT, accept without a last-word transfer: pend←p_data, pend_full←1. Accept is impossible while pend_full, because p_ready=0.
- SHIFT, no transfer: shreg and cnt hold, so s_data, s_first and s_last are stable while s_valid && !s_ready.
- s_data reads 0 whenever idle, because shreg is zero after reset and after the final shift.
- No data-dependent behaviour; p_data is not modified.

## Timing
- Reset (rst_n low, asynchronous, effective immediately):
  - shreg, pend, cnt = 0; active, pend_full = 0.
  - Outputs: s_valid=0, s_data=0, s_first=0, s_last=0, busy=0, p_ready=0.
  - p_ready rises combinationally with rst_n.
- Reset mid-block aborts the current block and discards any pending block. No partial words are emitted after release.
- Latency: accept in cycle N → s_valid=1 with word 0 in cycle N+1.
- Throughput: 1 word/cycle sustained when s_ready=1 and p_valid is held. Block N+1 word 0 immediately follows block N word BLOCK_SIZE-1.
- p_ready falls the cycle after a SHIFT-state accept into pend.
- p_ready rises the cycle after pend is moved into shreg.
- Inputs p_data/p_valid need not be held after acceptance.

## Test plan
- Reset: assert rst_n=0 mid-operation → all outputs 0 in the same cycle. After release, p_ready=1, s_valid=0.
- Single block: p_data=0x44332211 accepted in cycle 0, s_ready=1 → s_data 0x11, 0x22, 0x33, 0x44 in cycles 1–4. s_first only in cycle 1, s_last only in cycle 4. s_valid=0 and s_data=0 in cycle 5.
- Back-to-back: blocks 0x44332211 and 0x88776655 offered continuously, s_ready=1 → 8 consecutive words 0x11..0x88 with no gap. p_ready=0 exactly while the second block sits in pend.
- Backpressure: s_ready pattern 1,0,0,1,1,0,1 → each word held stable while stalled. Word order and s_first/s_last unchanged. Total transfers = 4.
- Pending full: s_ready=0, three blocks offered → first loaded into shreg, second into pend, third stalls with p_ready=0 until the first block's last word transfers. All 12 words then emerge in order.
- Loopback: s_data drives `s2p` s_data with s_ready=1 and block 0xDEADBEEF → four cycles after s_first, `s2p` p_data = 0xDEADBEEF.
